alu_uart_sequencer: RTL and testbench
=====================================

Name: alu_uart_sequencer

Overview:
- Sequential front end that drives the combinational ALU's operand and opcode inputs from a byte stream (UART receiver side) and returns the ALU result on a byte stream (UART transmitter side).
- Collects three bytes in order: operand A, operand B, opcode. It applies them to the ALU, captures the result, then requests one transmit.
- Sits between the UART RX/TX pair and the ALU in the top-level.

Parameters:
- NB_BITS, 8, data/operand width; also the byte-stream width.
- NB_OPE, 6, ALU opcode width; taken from the low NB_OPE bits of the opcode byte.
- TIMEOUT_CYCLES, 50000000, inter-byte timeout in clock cycles; only used when ALU_SEQ_TIMEOUT_EN is defined.

Ports:
- i_clock  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_rx_data  input  NB_BITS  received byte.
- i_rx_valid  input  1  one-cycle strobe: i_rx_data is valid this cycle.
- o_tx_data  output  NB_BITS  byte to transmit; holds the captured result.
- o_tx_start  output  1  one-cycle strobe requesting transmission of o_tx_data.
- i_tx_busy  input  1  transmitter busy; a start must not be issued while high.
- o_dato_a  output  NB_BITS  ALU operand A, registered.
- o_dato_b  output  NB_BITS  ALU operand B, registered.
- o_ope_sel  output  NB_OPE  ALU opcode, registered.
- i_alu_result  input  NB_BITS  combinational ALU result.
- o_busy  output  1  high in any state other than WAIT_A.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): state is WAIT_A. o_dato_a, o_dato_b, o_ope_sel, o_tx_data and the result register are 0; o_tx_start=0; o_busy=0.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A: on an edge with i_rx_valid=1, o_dato_a <= i_rx_data and go to WAIT_B.
- WAIT_B: on i_rx_valid=1, o_dato_b <= i_rx_data and go to WAIT_OP.
- WAIT_OP: on i_rx_valid=1, o_ope_sel <= i_rx_data[NB_OPE-1:0] (upper bits ignored) and go to EXEC.
- EXEC: exactly one cycle, so the ALU sees stable registered inputs. On the next edge, result <= i_alu_result and go to SEND.
- SEND: on the first edge where i_tx_busy=0, o_tx_data <= result and o_tx_start <= 1 for exactly one cycle, then go to WAIT_A. While i_tx_busy=1, stay in SEND with o_tx_start=0 and no limit on the wait.
- Latency: opcode byte sampled at edge t; result captured at t+1; o_tx_start is high during the cycle after edge t+2 when i_tx_busy=0.
- o_dato_a, o_dato_b and o_ope_sel hold their last values until the same field is overwritten. A partial new sequence therefore changes the ALU inputs field by field.
- An i_rx_valid pulse during EXEC or SEND is dropped and does not advance the next sequence.
- o_tx_start is never asserted in consecutive cycles and never in a cycle where i_tx_busy was high at the preceding edge.
- Unknown opcodes are passed through unchanged; the ALU returns 0 for them, and that 0 is transmitted normally.
- No arithmetic in this block; widths are pass-through only.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A counter resets to 0 on every accepted byte and on entry to WAIT_A.
  - In WAIT_B or WAIT_OP, the counter increments each cycle without i_rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, the next edge returns the FSM to WAIT_A. Operand registers keep their values and no transmit occurs.
  - The timeout is inactive in WAIT_A, EXEC and SEND.
- Not defined: no counter exists, and the FSM waits indefinitely for the next byte.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 with i_tx_busy=0 -> o_dato_a=0x05, o_dato_b=0x03, o_ope_sel=0x20; o_tx_data=0x08 with a single o_tx_start pulse two edges after the opcode byte.
- Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE. Bytes 0x80, 0x02, 0x03 (SRA) -> 0xE0. Bytes 0x80, 0x02, 0x02 (SRL) -> 0x20.
- Opcode byte 0xE4 -> o_ope_sel=0x24 (AND); with A=0xF0, B=0x3C, tx 0x30.
- i_tx_busy held high for 10 cycles after EXEC -> FSM stays in SEND with o_tx_start=0. o_tx_start pulses once on the first edge with busy low. An rx byte 0x55 injected during SEND is dropped, and the next A equals the following byte.
- Assert i_reset asynchronously (mid-cycle) while in WAIT_OP after A=0x11, B=0x22 -> all outputs 0 immediately and state WAIT_A. A full new sequence then works normally.
- With ALU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: send A=0x07, then idle 16 cycles -> FSM returns to WAIT_A with no tx. A following sequence 0x01, 0x01, 0x20 -> tx 0x02.

Source files
------------

// File: rtl/alu_uart_sequencer.sv
// Byte-stream front end for the ALU: collects A, B, opcode, executes, and hands the result to the UART TX (optional ALU_SEQ_TIMEOUT_EN inter-byte timeout).
// Latency: result captured one edge after the opcode byte; o_tx_start pulses on the following edge where i_tx_busy is low.
// Backpressure: waits in SEND for as long as i_tx_busy is high; rx bytes arriving during EXEC/SEND are dropped.
module alu_uart_sequencer #(
  parameter int NB_BITS        = 8,
  parameter int NB_OPE         = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BITS-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  output logic [NB_BITS-1:0] o_dato_a,
  output logic [NB_BITS-1:0] o_dato_b,
  output logic [NB_OPE-1:0]  o_ope_sel,
  input  logic [NB_BITS-1:0] i_alu_result,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t             state;
  logic [NB_BITS-1:0] result;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  assign o_busy = (state != WAIT_A);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= WAIT_A;
      o_dato_a   <= '0;
      o_dato_b   <= '0;
      o_ope_sel  <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      result     <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        WAIT_A: begin
`ifdef ALU_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (i_rx_valid) begin
            o_dato_a <= i_rx_data;
            state    <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (i_rx_valid) begin
            o_dato_b <= i_rx_data;
            state    <= WAIT_OP;
`ifdef ALU_SEQ_TIMEOUT_EN
            tmo_cnt  <= '0;
          end else if (tmo_cnt == CNT_LAST) begin
            tmo_cnt  <= '0;
            state    <= WAIT_A;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
`endif
          end
        end
        WAIT_OP: begin
          if (i_rx_valid) begin
            // Only the low bits select the ALU operation; the rest of the byte is ignored.
            o_ope_sel <= i_rx_data[NB_OPE-1:0];
            state     <= EXEC;
`ifdef ALU_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
          end else if (tmo_cnt == CNT_LAST) begin
            tmo_cnt   <= '0;
            state     <= WAIT_A;
          end else begin
            tmo_cnt   <= tmo_cnt + 1'b1;
`endif
          end
        end
        EXEC: begin
          // Operands have been stable for a full cycle, so the ALU output is settled.
          result <= i_alu_result;
          state  <= SEND;
        end
        SEND: begin
          if (!i_tx_busy) begin
            o_tx_data  <= result;
            o_tx_start <= 1'b1;
            state      <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a result scoreboard; define ALU_SEQ_TIMEOUT_EN to also exercise the timeout.
module tb_alu_uart_sequencer;

  localparam int NB_BITS = 8;
  localparam int NB_OPE  = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NB_BITS-1:0] rx_data = '0;
  logic               rx_valid = 1'b0;
  logic [NB_BITS-1:0] tx_data;
  logic               tx_start;
  logic               tx_busy = 1'b0;
  logic [NB_BITS-1:0] dato_a;
  logic [NB_BITS-1:0] dato_b;
  logic [NB_OPE-1:0]  ope_sel;
  logic [NB_BITS-1:0] alu_result;
  logic               busy;

  int total = 0;
  int bad   = 0;
  logic [NB_BITS-1:0] exp_q[$];
  logic busy_at_edge = 1'b0;
  logic prev_start   = 1'b0;

  always #5 clk = ~clk;

  alu_uart_sequencer #(
    .NB_BITS(NB_BITS),
    .NB_OPE(NB_OPE),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .i_tx_busy(tx_busy),
    .o_dato_a(dato_a),
    .o_dato_b(dato_b),
    .o_ope_sel(ope_sel),
    .i_alu_result(alu_result),
    .o_busy(busy)
  );

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu(dato_a, dato_b, ope_sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) busy_at_edge <= tx_busy;

  // Scoreboard: every start pulse must carry the oldest expected result.
  always @(negedge clk) begin
    if (tx_start) begin
      chk("start_not_back_to_back", {31'd0, prev_start}, 32'd0);
      chk("start_while_busy", {31'd0, busy_at_edge}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_tx", 32'd1, 32'd0);
      end else begin
        chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_start = tx_start;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    exp_q.push_back(alu(a, b, op[5:0]));
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, tx_start}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    chk("rst_dato_a", {24'd0, dato_a}, 32'h0);
    chk("rst_dato_b", {24'd0, dato_b}, 32'h0);
    chk("rst_ope_sel", {26'd0, ope_sel}, 32'h0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ADD with exact latency check
    send_seq(8'h05, 8'h03, 8'h20);
    chk("add_dato_a", {24'd0, dato_a}, 32'h05);
    chk("add_dato_b", {24'd0, dato_b}, 32'h03);
    chk("add_ope_sel", {26'd0, ope_sel}, 32'h20);
    chk("add_busy_exec", {31'd0, busy}, 32'd1);
    chk("add_no_start_t0", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    chk("add_no_start_t1", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    chk("add_start_t2", {31'd0, tx_start}, 32'd1);
    chk("add_tx_data", {24'd0, tx_data}, 32'h08);
    @(negedge clk);
    chk("add_start_single", {31'd0, tx_start}, 32'd0);
    chk("add_idle_busy", {31'd0, busy}, 32'd0);

    send_seq(8'h03, 8'h05, 8'h22);
    wait_tx("sub_tx");
    send_seq(8'h80, 8'h02, 8'h03);
    wait_tx("sra_tx");
    send_seq(8'h80, 8'h02, 8'h02);
    wait_tx("srl_tx");
    send_seq(8'hF0, 8'h3C, 8'hE4);
    chk("and_ope_sel_masked", {26'd0, ope_sel}, 32'h24);
    wait_tx("and_tx");
    send_seq(8'h12, 8'h34, 8'h3F);
    chk("unknown_ope_sel", {26'd0, ope_sel}, 32'h3F);
    wait_tx("unknown_tx");

    // Transmitter busy: hold in SEND, drop an rx byte arriving there
    tx_busy = 1'b1;
    send_seq(8'h0A, 8'h05, 8'h20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("busy_hold_start", {31'd0, tx_start}, 32'd0);
      chk("busy_hold_state", {31'd0, busy}, 32'd1);
      if (i == 3) begin
        rx_data  = 8'h55;
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
    end
    tx_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_start", {31'd0, tx_start}, 32'd1);
    @(negedge clk);
    chk("busy_release_single", {31'd0, tx_start}, 32'd0);
    send_seq(8'h01, 8'h02, 8'h25);
    chk("drop_next_a", {24'd0, dato_a}, 32'h01);
    wait_tx("or_tx");

    // Asynchronous reset in the middle of a sequence
    send_byte(8'h11);
    send_byte(8'h22);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dato_a", {24'd0, dato_a}, 32'h0);
    chk("arst_dato_b", {24'd0, dato_b}, 32'h0);
    chk("arst_tx_data", {24'd0, tx_data}, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_seq(8'h04, 8'h06, 8'h26);
    wait_tx("xor_after_rst_tx");

`ifdef ALU_SEQ_TIMEOUT_EN
    send_byte(8'h07);
    repeat (15) @(negedge clk);
    chk("tmo_still_waiting", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("tmo_back_to_idle", {31'd0, busy}, 32'd0);
    chk("tmo_keeps_a", {24'd0, dato_a}, 32'h07);
    repeat (3) @(negedge clk);
    send_seq(8'h01, 8'h01, 8'h20);
    wait_tx("tmo_followup_tx");
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
